capture_ctrl: RTL and testbench
===============================

# capture_ctrl

Sequencing controller for the four-channel input buffer (reference plus three signal channels). It converts a one-shot capture request into exactly NDATA per-sample write strobes and a matching write index. It then holds the completed frame with a valid/ack handshake until the downstream correlation stage has consumed it. It also tracks missed samples and counts completed frames.

## Interface
- NDATA, 128: samples per frame; any value ≥ 2 (power of two not required).
- Derived: CW = $clog2(NDATA), width of the write index.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  capture request pulse; honoured only in IDLE.
- abort  input  1  synchronous cancel; from any state, go to IDLE next cycle.
- sample_tick  input  1  one-cycle strobe: a new 4-bit sample is present on the buffer inputs.
- trig  input  1  reference-channel bit (din[0]); used only when CAPTURE_TRIG_EN is defined.
- buff_ena  output  1  registered write strobe to the input buffer.
- buff_cnt  output  CW  registered write index, valid while buff_ena = 1.
- busy  output  1  high in any state other than IDLE.
- data_valid  output  1  full frame held in buffer.
- data_ack  input  1  downstream has consumed the frame.
- overrun  output  1  sticky: sample_tick arrived while frame was held.
- frame_cnt  output  8  completed-frame counter; wraps 255 → 0.

## Operation
- States: IDLE, WAIT_TRIG (present only with CAPTURE_TRIG_EN), CAPTURE, HOLD.
- Reset values: state IDLE; buff_ena 0; buff_cnt 0; busy 0; data_valid 0; overrun 0; frame_cnt 0.
- IDLE + start:
  - Go to WAIT_TRIG (with macro) or CAPTURE (without).
  - Internal index clears to 0; overrun clears.
- CAPTURE, each sample_tick:
  - Next cycle: buff_ena = 1 and buff_cnt = current index.
  - Index increments.
  - On the tick that writes index NDATA-1: go to HOLD. No natural wrap of the index is relied on.
- CAPTURE, no tick: buff_ena = 0 and buff_cnt holds its last value.
- HOLD:
  - data_valid = 1.
  - sample_tick sets overrun; no write occurs.
  - data_ack: data_valid drops next cycle, state returns to IDLE, frame_cnt increments.
- abort:
  - Overrides every other input, including a simultaneous start, data_ack or final tick.
  - Next cycle: IDLE, buff_ena 0, data_valid 0, index 0.
  - frame_cnt unchanged; overrun retained.
- start outside IDLE is ignored, including start in the same cycle as data_ack. Requester must re-assert start after busy falls.
- rst mid-capture: all outputs return to reset values next cycle, including frame_cnt.

## Timing
- start → busy = 1: 1 cycle.
- sample_tick → buff_ena/buff_cnt: exactly 1 cycle, fixed.
- Final tick (index NDATA-1) at cycle t:
  - buff_ena at t+1.
  - data_valid = 1 at t+1, same cycle as the last write strobe.
  - Consumers must not read the buffer before t+2.
- data_ack at cycle t → data_valid = 0, busy = 0, frame_cnt + 1 at t+1.
- Back-to-back ticks on consecutive cycles are supported: one write strobe per tick, none dropped.
- Minimum frame duration: NDATA cycles.

## Configuration
- CAPTURE_TRIG_EN defined:
  - After start, the block waits in WAIT_TRIG.
  - trig is sampled only on sample_tick cycles; prev_trig is preset to 1 at start, so a level already high at start does not trigger.
  - The first tick with trig = 1 and prev_trig = 0 is written as index 0, then the block continues in CAPTURE.
  - Ticks before the trigger are discarded with no strobe.
  - abort is the only exit if no edge ever arrives.
- CAPTURE_TRIG_EN undefined: WAIT_TRIG and prev_trig are not built; trig is ignored; the first tick after start is index 0.

## Test plan
- Reset: hold rst 2 cycles mid-capture (index 37) → all outputs zero next cycle; a following start captures from index 0.
- Basic frame, NDATA = 128, tick every 3 cycles:
  - Exactly 128 buff_ena pulses, buff_cnt 0..127 in order.
  - data_valid rises with strobe 127; data_ack → frame_cnt = 1.
- Continuous ticks every cycle, NDATA = 5 → strobes on 5 consecutive cycles with indices 0..4; data_valid in the cycle of index 4.
- Overrun: 3 ticks during HOLD → no strobes, overrun = 1. The next start clears it.
- Abort and ignored starts:
  - abort at index 60 → IDLE, no data_valid, frame_cnt unchanged.
  - start during CAPTURE → ignored.
  - start + data_ack in the same cycle → IDLE, no new capture.
- CAPTURE_TRIG_EN:
  - trig high at start → no trigger.
  - trig 1,1,0,0,1 on ticks → capture begins on the 5th tick as index 0.

Source files
------------

// File: rtl/capture_ctrl_if.sv
// Handshake and buffer-write bundle between capture_ctrl and its requester/consumer.
// master = requester/consumer side, slave = capture_ctrl.
interface capture_ctrl_if #(
  parameter int NDATA = 128
);
  localparam int CW = $clog2(NDATA);

  logic          start;
  logic          abort;
  logic          sample_tick;
  logic          trig;
  logic          data_ack;
  logic          buff_ena;
  logic [CW-1:0] buff_cnt;
  logic          busy;
  logic          data_valid;
  logic          overrun;
  logic [7:0]    frame_cnt;

  modport master (
    output start, abort, sample_tick, trig, data_ack,
    input  buff_ena, buff_cnt, busy, data_valid, overrun, frame_cnt
  );

  modport slave (
    input  start, abort, sample_tick, trig, data_ack,
    output buff_ena, buff_cnt, busy, data_valid, overrun, frame_cnt
  );
endinterface

// File: rtl/capture_ctrl.sv
// Capture sequencer: turns a start request into NDATA buffer write strobes, then holds
// the frame under a valid/ack handshake. Optional trigger wait built with CAPTURE_TRIG_EN.
module capture_ctrl #(
  parameter  int NDATA = 128,
  localparam int CW    = $clog2(NDATA)
) (
  input  logic          clk,
  input  logic          rst,
  capture_ctrl_if.slave bus
);

`ifdef CAPTURE_TRIG_EN
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    HOLD      = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_e;
`endif

  localparam logic [CW-1:0] LAST_IDX = CW'(NDATA - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          buff_ena_q, buff_ena_d;
  logic [CW-1:0] buff_cnt_q, buff_cnt_d;
  logic          data_valid_q, data_valid_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

`ifdef CAPTURE_TRIG_EN
  logic          prev_trig_q, prev_trig_d;
`else
  logic          unused_trig;
  assign unused_trig = bus.trig;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    buff_ena_d   = 1'b0;
    buff_cnt_d   = buff_cnt_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    frame_cnt_d  = frame_cnt_q;
`ifdef CAPTURE_TRIG_EN
    prev_trig_d  = prev_trig_q;
`endif

    // abort outranks start, data_ack and the final tick alike
    if (bus.abort) begin
      state_d      = IDLE;
      idx_d        = '0;
      data_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
`ifdef CAPTURE_TRIG_EN
            state_d     = WAIT_TRIG;
            prev_trig_d = 1'b1;
`else
            state_d     = CAPTURE;
`endif
            idx_d       = '0;
            overrun_d   = 1'b0;
          end
        end
`ifdef CAPTURE_TRIG_EN
        WAIT_TRIG: begin
          // trigger tick itself is the first sample of the frame
          if (bus.sample_tick) begin
            prev_trig_d = bus.trig;
            if (bus.trig && !prev_trig_q) begin
              buff_ena_d = 1'b1;
              buff_cnt_d = '0;
              idx_d      = CW'(1);
              state_d    = CAPTURE;
            end
          end
        end
`endif
        CAPTURE: begin
          if (bus.sample_tick) begin
            buff_ena_d = 1'b1;
            buff_cnt_d = idx_q;
            if (idx_q == LAST_IDX) begin
              state_d      = HOLD;
              data_valid_d = 1'b1;
              idx_d        = '0;
            end else begin
              idx_d = idx_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (bus.sample_tick) overrun_d = 1'b1;
          if (bus.data_ack) begin
            data_valid_d = 1'b0;
            state_d      = IDLE;
            frame_cnt_d  = frame_cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      buff_ena_q   <= 1'b0;
      buff_cnt_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_cnt_q  <= 8'd0;
`ifdef CAPTURE_TRIG_EN
      prev_trig_q  <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      buff_ena_q   <= buff_ena_d;
      buff_cnt_q   <= buff_cnt_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      frame_cnt_q  <= frame_cnt_d;
`ifdef CAPTURE_TRIG_EN
      prev_trig_q  <= prev_trig_d;
`endif
    end
  end

  assign bus.buff_ena   = buff_ena_q;
  assign bus.buff_cnt   = buff_cnt_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.data_valid = data_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: NDATA=128 instance for frame/abort/overrun behaviour,
// NDATA=5 instance for back-to-back ticks; trigger scenario when CAPTURE_TRIG_EN is defined.
module tb_capture_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  capture_ctrl_if #(.NDATA(128)) a_if ();
  capture_ctrl_if #(.NDATA(5))   b_if ();

  capture_ctrl #(.NDATA(128)) u_dut_a (.clk(clk), .rst(rst), .bus(a_if));
  capture_ctrl #(.NDATA(5))   u_dut_b (.clk(clk), .rst(rst), .bus(b_if));

  int n_checks = 0;
  int n_errors = 0;
  int q_a[$];
  int q_b[$];
  int a_strobes = 0;
  int b_strobes = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboards: every write strobe must match the next queued index
  always @(negedge clk) begin
    if (a_if.buff_ena === 1'b1) begin
      a_strobes++;
      if (q_a.size() == 0) check_eq("a_unexpected_strobe", int'(a_if.buff_cnt), -1);
      else check_eq("a_buff_cnt", int'(a_if.buff_cnt), q_a.pop_front());
    end
    if (b_if.buff_ena === 1'b1) begin
      b_strobes++;
      if (q_b.size() == 0) check_eq("b_unexpected_strobe", int'(b_if.buff_cnt), -1);
      else begin
        int e;
        e = q_b.pop_front();
        check_eq("b_buff_cnt", int'(b_if.buff_cnt), e);
        check_eq("b_dv_with_strobe", int'(b_if.data_valid), (e == 4) ? 1 : 0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_a(input bit push, input int val, input int gap);
    if (push) q_a.push_back(val);
    a_if.sample_tick = 1'b1;
    cyc(1);
    a_if.sample_tick = 1'b0;
    if (gap > 1) cyc(gap - 1);
  endtask

  task automatic pulse_a_start();
    a_if.start = 1'b1;
    cyc(1);
    a_if.start = 1'b0;
  endtask

  task automatic pulse_a_ack();
    a_if.data_ack = 1'b1;
    cyc(1);
    a_if.data_ack = 1'b0;
  endtask

  task automatic full_frame_a(input int gap);
    for (int i = 0; i < 128; i++) begin
      tick_a(1'b1, i, (i == 127) ? 1 : gap);
      if (i == 126) check_eq("a_dv_before_last", int'(a_if.data_valid), 0);
    end
    check_eq("a_dv_with_last", int'(a_if.data_valid), 1);
    check_eq("a_ena_last", int'(a_if.buff_ena), 1);
    check_eq("a_cnt_last", int'(a_if.buff_cnt), 127);
  endtask

  initial begin
    int s0;
    {a_if.start, a_if.abort, a_if.sample_tick, a_if.trig, a_if.data_ack} = '0;
    {b_if.start, b_if.abort, b_if.sample_tick, b_if.trig, b_if.data_ack} = '0;

    rst = 1'b1;
    cyc(2);
    check_eq("rst_busy", int'(a_if.busy), 0);
    check_eq("rst_frame_cnt", int'(a_if.frame_cnt), 0);
    rst = 1'b0;
    cyc(1);

    // reset in the middle of a capture (after index 36 written)
    pulse_a_start();
    check_eq("start_busy", int'(a_if.busy), 1);
    for (int i = 0; i < 37; i++) tick_a(1'b1, i, 1);
    rst = 1'b1;
    cyc(1);
    check_eq("midrst_ena", int'(a_if.buff_ena), 0);
    check_eq("midrst_cnt", int'(a_if.buff_cnt), 0);
    check_eq("midrst_busy", int'(a_if.busy), 0);
    check_eq("midrst_dv", int'(a_if.data_valid), 0);
    check_eq("midrst_ovr", int'(a_if.overrun), 0);
    check_eq("midrst_frame", int'(a_if.frame_cnt), 0);
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // basic frame, tick every 3 cycles
    s0 = a_strobes;
    pulse_a_start();
    full_frame_a(3);
    pulse_a_ack();
    check_eq("ack_dv", int'(a_if.data_valid), 0);
    check_eq("ack_busy", int'(a_if.busy), 0);
    check_eq("ack_frame1", int'(a_if.frame_cnt), 1);
    check_eq("frame_strobes", a_strobes - s0, 128);

    // overrun during HOLD, back-to-back ticks
    pulse_a_start();
    full_frame_a(1);
    for (int i = 0; i < 3; i++) tick_a(1'b0, 0, 1);
    check_eq("ovr_set", int'(a_if.overrun), 1);
    check_eq("ovr_dv_held", int'(a_if.data_valid), 1);
    pulse_a_ack();
    check_eq("ovr_frame2", int'(a_if.frame_cnt), 2);
    check_eq("ovr_sticky", int'(a_if.overrun), 1);
    pulse_a_start();
    check_eq("ovr_cleared", int'(a_if.overrun), 0);

    // ignored start mid-capture, then abort at index 60
    for (int i = 0; i < 30; i++) tick_a(1'b1, i, 1);
    pulse_a_start();
    for (int i = 30; i < 60; i++) tick_a(1'b1, i, 1);
    a_if.abort = 1'b1;
    cyc(1);
    a_if.abort = 1'b0;
    check_eq("abort_busy", int'(a_if.busy), 0);
    check_eq("abort_ena", int'(a_if.buff_ena), 0);
    check_eq("abort_dv", int'(a_if.data_valid), 0);
    check_eq("abort_frame", int'(a_if.frame_cnt), 2);
    tick_a(1'b0, 0, 1);
    tick_a(1'b0, 0, 1);
    a_if.start = 1'b1;
    a_if.abort = 1'b1;
    cyc(1);
    a_if.start = 1'b0;
    a_if.abort = 1'b0;
    check_eq("start_abort_busy", int'(a_if.busy), 0);

    // restart after abort begins at index 0; start with ack is ignored
    pulse_a_start();
    full_frame_a(1);
    a_if.start = 1'b1;
    a_if.data_ack = 1'b1;
    cyc(1);
    a_if.start = 1'b0;
    a_if.data_ack = 1'b0;
    check_eq("startack_busy", int'(a_if.busy), 0);
    check_eq("startack_frame3", int'(a_if.frame_cnt), 3);
    cyc(2);
    check_eq("startack_still_idle", int'(a_if.busy), 0);
    tick_a(1'b0, 0, 2);

    // NDATA=5, ticks on consecutive cycles
    b_if.start = 1'b1;
    cyc(1);
    b_if.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      q_b.push_back(i);
      b_if.sample_tick = 1'b1;
      cyc(1);
    end
    b_if.sample_tick = 1'b0;
    check_eq("b_dv", int'(b_if.data_valid), 1);
    cyc(1);
    check_eq("b_strobes", b_strobes, 5);
    b_if.data_ack = 1'b1;
    cyc(1);
    b_if.data_ack = 1'b0;
    check_eq("b_frame1", int'(b_if.frame_cnt), 1);

`ifdef CAPTURE_TRIG_EN
    // level already high at start never triggers; rising edge on 5th tick does
    a_if.trig = 1'b1;
    pulse_a_start();
    tick_a(1'b0, 0, 2);
    tick_a(1'b0, 0, 2);
    a_if.trig = 1'b0;
    tick_a(1'b0, 0, 2);
    tick_a(1'b0, 0, 2);
    check_eq("trig_wait_busy", int'(a_if.busy), 1);
    a_if.trig = 1'b1;
    tick_a(1'b1, 0, 1);
    for (int i = 1; i < 128; i++) begin
      a_if.trig = 1'($urandom_range(0, 1));
      tick_a(1'b1, i, 1);
    end
    check_eq("trig_dv", int'(a_if.data_valid), 1);
    pulse_a_ack();
    check_eq("trig_frame4", int'(a_if.frame_cnt), 4);
`endif

    cyc(3);
    check_eq("a_queue_drained", q_a.size(), 0);
    check_eq("b_queue_drained", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
